// File: rtl/rx_queue_if.sv
// Receive-queue bundle: serial-receiver side (rx_*), consumer side (num_*),
// and status/control. The slave modport is the queue, the master is its environment.
interface rx_queue_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              rx_stop;
    logic [WIDTH-1:0]  rx_data;
    logic              rx_en;
    logic [WIDTH-1:0]  number;
    logic              num_valid;
    logic              num_ready;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              ovf_clr;

    // Handshake: a word leaves the queue on every rising clk edge where
    // num_valid & num_ready are both high; number is valid (and non-zero-forced)
    // only while num_valid is high, and num_valid never depends on num_ready.
    modport slave (
        input  rx_stop, rx_data, num_ready, ovf_clr,
        output rx_en, number, num_valid, level, overflow
    );

    modport master (
        output rx_stop, rx_data, num_ready, ovf_clr,
        input  rx_en, number, num_valid, level, overflow
    );
endinterface

// File: rtl/rx_queue.sv
// First-word-fall-through byte queue between the UART receiver and the decoder.
// Optional feature macro: RXQ_FILTER_EN (discard words equal to FILTER_CODE).
module rx_queue #(
    parameter int              WIDTH       = 8,
    parameter int              ADDR_W      = 3,
    parameter logic [7:0]      FILTER_CODE = 8'h0A
) (
    input  logic      clk,
    input  logic      rst,
    rx_queue_if.slave q
);
    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [WIDTH-1:0]  FILT    = WIDTH'(FILTER_CODE);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              stop_d;
    logic              overflow;

    logic push_req;
    logic filtered;
    logic full;
    logic num_valid;
    logic pop;
    logic push_ok;
    logic ovf_set;

    assign push_req = q.rx_stop & ~stop_d;

`ifdef RXQ_FILTER_EN
    assign filtered = (q.rx_data == FILT);
`else
    logic unused_filter;
    assign unused_filter = ^FILT;
    assign filtered      = 1'b0;
`endif

    assign full      = (level == DEPTH_L);
    assign num_valid = (level != '0);
    assign pop       = num_valid & q.num_ready;
    // A pop in the same cycle frees a slot, so a push into a full queue survives.
    assign push_ok   = push_req & ~filtered & (~full | pop);
    assign ovf_set   = push_req & ~filtered & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_d   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            stop_d <= q.rx_stop;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level <= level + 1'b1;
            else if (pop && !push_ok) level <= level - 1'b1;
            if (ovf_set)        overflow <= 1'b1;
            else if (q.ovf_clr) overflow <= 1'b0;
        end
    end

    // Storage is deliberately not reset; number is gated by num_valid instead.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= q.rx_data;
    end

    assign q.number    = num_valid ? mem[rd_ptr] : '0;
    assign q.num_valid = num_valid;
    assign q.rx_en     = ~full;
    assign q.level     = level;
    assign q.overflow  = overflow;
endmodule

// File: doc/rx_queue.md
# rx_queue

Parametrised receive-side byte queue between the UART receiver and the note/tempo decoder of the beeper player. It captures one word per completed serial frame (rising edge of `rx_stop`), buffers up to `DEPTH` words in a first-word-fall-through FIFO, and presents them downstream with a valid/ready handshake. It throttles the receiver through `rx_en` when full and records dropped words in a sticky overflow flag.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits
- `ADDR_W`, 3, pointer width; `DEPTH = 2**ADDR_W`; legal range 1..6
- `FILTER_CODE`, 8'h0A, word value discarded when `RXQ_FILTER_EN` is defined; only the low `WIDTH` bits are used

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rx_stop`  in  1  receiver frame-complete level; a rising edge marks a new word
- `rx_data`  in  WIDTH  received word, stable while `rx_stop` is high
- `rx_en`  out  1  receiver enable; high when the queue is not full
- `number`  out  WIDTH  head-of-queue word; forced to 0 when `num_valid` is low
- `num_valid`  out  1  queue not empty
- `num_ready`  in  1  consumer pop; a pop occurs when `num_valid & num_ready`
- `level`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky; set when a word arrives while full
- `ovf_clr`  in  1  synchronous clear of `overflow`

## Operation
- Edge detect: register `stop_d <= rx_stop`. A push request is `rx_stop & ~stop_d`. One word is captured per frame, however long `rx_stop` stays high.
- Push request with `level < DEPTH`: write `rx_data` at `wr_ptr`, then `wr_ptr++`.
- Push request with `level == DEPTH` and no pop in the same cycle: drop the word and set `overflow`.
- Push request with `level == DEPTH` and a pop in the same cycle: accept the push; `level` stays at DEPTH and `overflow` is unchanged.
- Push request with `level == 0` and `num_ready` high: the push is accepted and no pop occurs, because `num_valid` is low.
- Pop: `rd_ptr++`.
- `level` update per cycle: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Both pointers wrap modulo DEPTH with natural binary overflow. Full and empty are derived from `level`, not from pointer comparison.
- `number = num_valid ? mem[rd_ptr] : 0`. The read is combinational from the registered pointer, so the queue is first-word-fall-through.
- `rx_en = (level != DEPTH)`, decoded from the registered `level`.
- `overflow`: a set condition in the same cycle as `ovf_clr` wins, so the flag stays 1. Otherwise `ovf_clr` clears it.
- Memory contents are not reset. Outputs stay deterministic because `number` is gated by `num_valid`.

## Timing
- Reset values: `level=0`, `wr_ptr=rd_ptr=0`, `overflow=0`, `stop_d=1`, `num_valid=0`, `number=0`, `rx_en=1`.
- Because `stop_d` resets to 1, an `rx_stop` held high through reset release does not push. The first push needs a low-then-high transition.
- Push latency: when the `rx_stop` rise is sampled at edge k, `num_valid` and `number` are valid after edge k (one cycle).
- Pop latency: when the pop is sampled at edge k, the next word, or `num_valid=0`, appears after edge k.
- `rx_en` falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from full.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Queued words are lost.

## Configuration
- `RXQ_FILTER_EN` defined: a push request whose `rx_data == FILTER_CODE` is discarded. It does not write, does not change `level`, and never sets `overflow`, even when the queue is full.
- `RXQ_FILTER_EN` undefined: every value is queued. `FILTER_CODE` is unused.

## Test plan
- Reset, then push 8'h3C: after 1 cycle `num_valid=1`, `number=8'h3C`, `level=1`. Pop: `num_valid=0`, `number=0`.
- Hold `rx_stop` high for 20 cycles with data 8'h11: exactly one word is queued (`level=1`).
- DEPTH=8: push 8'h01..8'h08 with no pops, giving `level=8` and `rx_en=0`. Push 8'h09: dropped, `overflow=1`. Pop all: sequence 01..08. Pulse `ovf_clr`: `overflow=0`.
- Full queue, push 8'hAA while `num_ready=1` in the same cycle: `level` stays 8, `overflow` stays 0, and 8'hAA is the last word read out.
- Push 8'h0A with `RXQ_FILTER_EN` defined: `level` stays 0. Without the macro: `level=1`, `number=8'h0A`.
- Assert `rst` with `level=5` and `overflow=1`: `level=0`, `overflow=0`, `rx_en=1` with no clock edge. Holding `rx_stop=1` across the reset release causes no push.
